// File: rtl/mux_scan_serializer_if.sv
// rtl/mux_scan_serializer_if.sv - word-in / bit-out handshake bundle for mux_scan_serializer
//
// Purpose: groups the parallel input port and the serial output port of the
// serializer so producer/consumer and serializer connect through one handle.
//
// Signals:
//   in_valid   producer -> serializer   in_data is valid
//   in_ready   serializer -> producer   serializer can take a word
//   in_data    producer -> serializer   WIDTH-bit parallel word
//   out_valid  serializer -> consumer   out_bit is valid
//   out_ready  consumer -> serializer   consumer takes out_bit this cycle
//   out_bit    serializer -> consumer   current serial bit
//   out_last   serializer -> consumer   marks the final bit of the word
//
// Modports:
//   master  producer/consumer side (drives in_valid, in_data, out_ready)
//   slave   serializer side
interface mux_scan_serializer_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - parallel-to-serial converter driving a WIDTH:1 bit mux select
//
// Purpose: latches one WIDTH-bit word, then walks the mux select from 0 to
// WIDTH-1 emitting one bit per accepted serial beat, LSB first.
//
// muxer64 ports:
//   in_i   WIDTH  mux data inputs
//   sel_i  SEL_W  select
//   q_o    1      in_i[sel_i]
//
// mux_scan_serializer ports:
//   clk    1      rising-edge clock
//   rst_n  1      asynchronous active-low reset
//   flush  1      synchronous abort back to IDLE (word_q kept)
//   bus    slave  in_valid/in_ready/in_data, out_valid/out_ready/out_bit/out_last
//   sel    SEL_W  current mux select (debug/checking)
//   busy   1      high while shifting a word out

module muxer64 #(
  parameter int WIDTH = 64,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             q_o
);
  assign q_o = in_i[sel_i];
endmodule

module mux_scan_serializer #(
  parameter int WIDTH = 64,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  mux_scan_serializer_if.slave        bus,
  output logic [SEL_W-1:0]            sel,
  output logic                        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Terminal count compared explicitly so the counter never relies on wrap.
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] word_q, word_d;

  logic in_fire;
  logic beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      word_q  <= word_d;
    end
  end

  // Handshake outputs depend on the registered state only, so an async
  // reset forces them to their idle values without a clock edge.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == SHIFT);
  assign bus.out_last  = (state_q == SHIFT) && (sel_q == LAST_SEL);
  assign busy          = (state_q == SHIFT);
  assign sel           = sel_q;

  assign in_fire = bus.in_valid && bus.in_ready;
  assign beat    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    word_d  = word_q;

    // flush wins over both a beat and an input accept; word_q is left alone.
    if (flush) begin
      state_d = IDLE;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            word_d  = bus.in_data;
            sel_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (sel_q == LAST_SEL) begin
              sel_d   = '0;
              state_d = IDLE;
            end else begin
              sel_d = sel_q + SEL_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = '0;
        end
      endcase
    end
  end

  muxer64 #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_i  (word_q),
    .sel_i (sel_q),
    .q_o   (bus.out_bit)
  );

endmodule
